// File: rtl/mdu_unit_if.sv
// ---------------------------------------------------------------------------
// mdu_unit_if
// Groups the operation request and result signals exchanged between the
// execute stage and the multiply/divide unit.
//   start  : qualifies MDUOp for one cycle
//   MDUOp  : 4-bit operation code
//   A, B   : 32-bit rs / rt operands
//   busy   : high while an operation is in flight
//   HI, LO : architectural HI / LO registers
// The master modport is the execute stage; the slave modport is mdu_unit.
// ---------------------------------------------------------------------------
interface mdu_unit_if;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, MDUOp, A, B, input busy, HI, LO);
  modport slave  (input start, MDUOp, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// ---------------------------------------------------------------------------
// mdu_unit
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed in the start cycle and parked in pending registers;
// a counter then models the multi-cycle latency before HI/LO are committed.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   mduBus : mdu_unit_if.slave (start, MDUOp, A, B in; busy, HI, LO out)
// Parameters:
//   MULT_CYCLES : busy cycles for multiply-class ops (1..15)
//   DIV_CYCLES  : busy cycles for div/divu (1..15)
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (7..10),
// accumulating into {HI,LO}. Without it those codes behave as NONE.
// ---------------------------------------------------------------------------
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave mduBus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_count;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pendHi;
  logic [31:0] r_pendLo;

  logic        w_launch;
  logic        w_commit;
  logic        w_writeHi;
  logic        w_writeLo;
  logic [3:0]  w_loadCount;
  logic [31:0] w_resHi;
  logic [31:0] w_resLo;

  logic        w_isMul;
  logic        w_isDiv;
  logic        w_isMulLat;
  logic [63:0] w_prodS;
  logic [63:0] w_prodU;

  logic        w_divSigned;
  logic        w_divZero;
  logic [31:0] w_divA;
  logic [31:0] w_divB;
  logic [31:0] w_quotRaw;
  logic [31:0] w_remRaw;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_isMul = (mduBus.MDUOp == OP_MULT) || (mduBus.MDUOp == OP_MULTU);
  assign w_isDiv = (mduBus.MDUOp == OP_DIV)  || (mduBus.MDUOp == OP_DIVU);

`ifdef MDU_MADD_EN
  logic w_isMacc;
  assign w_isMacc   = (mduBus.MDUOp >= OP_MADD) && (mduBus.MDUOp <= OP_MSUBU);
  assign w_isMulLat = w_isMul | w_isMacc;
`else
  assign w_isMulLat = w_isMul;
`endif

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_prodS = {{32{mduBus.A[31]}}, mduBus.A} * {{32{mduBus.B[31]}}, mduBus.B};
  assign w_prodU = {32'd0, mduBus.A} * {32'd0, mduBus.B};

  // Signed division runs on magnitudes and fixes signs afterwards, which also
  // makes 0x80000000 / -1 wrap cleanly to 0x80000000 with remainder 0.
  assign w_divSigned = (mduBus.MDUOp == OP_DIV);
  assign w_divZero   = (mduBus.B == 32'd0);
  assign w_divA      = (w_divSigned && mduBus.A[31]) ? (~mduBus.A + 32'd1) : mduBus.A;
  assign w_divB      = (w_divSigned && mduBus.B[31]) ? (~mduBus.B + 32'd1) : mduBus.B;
  assign w_quotRaw   = w_divZero ? 32'd0 : (w_divA / w_divB);
  assign w_remRaw    = w_divZero ? 32'd0 : (w_divA % w_divB);
  assign w_quot      = (w_divSigned && (mduBus.A[31] ^ mduBus.B[31])) ? (~w_quotRaw + 32'd1) : w_quotRaw;
  assign w_rem       = (w_divSigned && mduBus.A[31]) ? (~w_remRaw + 32'd1) : w_remRaw;

  // Result that will be parked in the pending registers when an op launches.
  always_comb begin
    w_resHi = 32'd0;
    w_resLo = 32'd0;
    case (mduBus.MDUOp)
      OP_MULT:  {w_resHi, w_resLo} = w_prodS;
      OP_MULTU: {w_resHi, w_resLo} = w_prodU;
      OP_DIV, OP_DIVU: begin
        if (w_divZero) begin
          w_resHi = mduBus.A;
          w_resLo = 32'hFFFF_FFFF;
        end else begin
          w_resHi = w_rem;
          w_resLo = w_quot;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {w_resHi, w_resLo} = {r_hi, r_lo} + w_prodS;
      OP_MADDU: {w_resHi, w_resLo} = {r_hi, r_lo} + w_prodU;
      OP_MSUB:  {w_resHi, w_resLo} = {r_hi, r_lo} - w_prodS;
      OP_MSUBU: {w_resHi, w_resLo} = {r_hi, r_lo} - w_prodU;
`endif
      default: ;
    endcase
  end

  // Next-state and control decode. Any start seen while in RUN is dropped.
  always_comb begin
    w_nextState = r_state;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    w_writeHi   = 1'b0;
    w_writeLo   = 1'b0;
    w_loadCount = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (mduBus.start) begin
          if (w_isMulLat) begin
            w_launch    = 1'b1;
            w_loadCount = 4'(MULT_CYCLES);
            w_nextState = S_RUN;
          end else if (w_isDiv) begin
            w_launch    = 1'b1;
            w_loadCount = 4'(DIV_CYCLES);
            w_nextState = S_RUN;
          end else if (mduBus.MDUOp == OP_MTHI) begin
            w_writeHi = 1'b1;
          end else if (mduBus.MDUOp == OP_MTLO) begin
            w_writeLo = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_count == 4'd1) begin
          w_commit    = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Latency counter, pending result and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= 4'd0;
      r_busy   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_pendHi <= 32'd0;
      r_pendLo <= 32'd0;
    end else begin
      if (w_launch) begin
        r_count  <= w_loadCount;
        r_pendHi <= w_resHi;
        r_pendLo <= w_resLo;
        r_busy   <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_count <= r_count - 4'd1;
      end
      if (w_commit) begin
        r_hi   <= r_pendHi;
        r_lo   <= r_pendLo;
        r_busy <= 1'b0;
      end
      if (w_writeHi) r_hi <= mduBus.A;
      if (w_writeLo) r_lo <= mduBus.A;
    end
  end

  assign mduBus.busy = r_busy;
  assign mduBus.HI   = r_hi;
  assign mduBus.LO   = r_lo;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage next to the ALU. Consumes the same rs/rt operand values the ALU receives; its HI/LO outputs feed the GRF write-data mux for mfhi/mflo.
- Exposes a busy flag so the hazard/stall logic can hold mult/div/mfhi/mflo/mthi/mtlo while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, number of busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  qualifies MDUOp for one cycle.
- MDUOp  input  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7-10 as in Optional Feature; others treated as NONE.
- A  input  32  operand rs.
- B  input  32  operand rt.
- busy  output  1  registered; high while an operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (reset==0, asynchronous):
  - HI=0, LO=0, busy=0.
  - Internal counter=0, pending HI/LO=0, FSM to IDLE.
  - Reset mid-operation aborts the operation; no commit occurs.
- FSM states: IDLE and RUN.
- IDLE, start=1 and MDUOp in MULT/MULTU/DIV/DIVU:
  - Compute the result from A/B in that cycle and latch it into pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next edge; go to RUN.
- IDLE, start=1 and MDUOp in MTHI/MTLO:
  - HI<=A (MTHI) or LO<=A (MTLO) at that edge.
  - busy stays 0; remain in IDLE.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter goes 1->0: HI/LO <= pending, busy<=0, go to IDLE.
  - Latency: start at edge t gives busy high for exactly N cycles (edges t+1..t+N); new HI/LO are visible after edge t+N.
- start=1 while busy=1: ignored completely, including MTHI/MTLO. The hazard unit must stall on (start|busy); the MDU does not queue.
- HI/LO hold their old values throughout RUN. They change only on commit, MTHI/MTLO, or reset.
- MULT: signed 32x32 -> 64-bit product; HI=product[63:32], LO=product[31:0].
- MULTU: same as MULT, unsigned.
- DIV (signed):
  - LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned quotient to LO, remainder to HI.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=A. Busy for the full DIV_CYCLES.
- NONE or an unknown op with start=1: no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op codes 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU are legal.
  - {HI,LO} +/- (A*B), signed or unsigned per op, modulo 2^64.
  - The accumulator base is the {HI,LO} value at the start cycle.
  - Latency MULT_CYCLES; same busy/commit rules as MULT.
- Not defined: codes 7-10 behave as NONE and no accumulate logic is synthesized.

Test Plan:
- Reset release, then MULT A=0xFFFFFFFF B=0x00000002 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU A=0xFFFFFFFF B=0x00000002 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; HI/LO keep their prior values during busy.
- DIV A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7 B=0 -> LO=0xFFFFFFFF, HI=0x00000007. Then DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x12345678 in IDLE -> HI=0x12345678 next edge, busy stays 0. Then start MULT, and in cycle 2 of busy issue MTLO A=0xDEADBEEF -> ignored; LO ends with the product.
- Start DIV, drive reset=0 at cycle 4 (between edges) -> busy, HI, LO immediately 0. After release, no commit occurs.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU A=1 B=1 -> HI=1, LO=0. Without MDU_MADD_EN: same stimulus -> HI/LO unchanged, busy stays 0.
